fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared opcode constants, FSM encoding and buffer entry type for the fetch unit
package fetch_unit_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_OP_IMM = 7'd19;
    localparam logic [6:0] OPC_AUIPC  = 7'd23;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_OP     = 7'd51;
    localparam logic [6:0] OPC_LUI    = 7'd55;
    localparam logic [6:0] OPC_BRANCH = 7'd99;
    localparam logic [6:0] OPC_JALR   = 7'd103;
    localparam logic [6:0] OPC_JAL    = 7'd111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decoder-side signals of the fetch unit
// master: fetch unit side (drives requests and decoded outputs); slave: memory/core side
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;

    modport master (
        output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_opcode, out_funct3, out_funct7,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_opcode, out_funct3, out_funct7,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry instruction buffer with push/pop/flush
// ports: clk, rst_n (async, active-low), push/wdata, pop/rdata (head), flush, full, empty, count
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;

    assign wr_d    = flush ? '0 : push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = flush ? '0 : pop ? rd_q + 1'b1 : rd_q;
    assign count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);

    assign rdata = mem_q[rd_q];
    assign count = count_q;
    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk)
        if (push && !flush) mem_q[wr_q] <= wdata;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetcher with redirect flush and registered decode buffer
// ports: clk, rst_n (async, active-low), bus (fetch_unit_if.master: imem req/rsp, redirect, decoder output)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_unit_if.master   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count;
    logic          accept, rsp, redir, push, pop, empty, full;
    logic [31:0]   target;
    fetch_entry_t  head;
    logic [63:0]   rdata;

    assign target = bus.redirect_pc & ~32'h3;
    assign redir  = bus.redirect_valid && state_q != ST_IDLE;
    assign rsp    = bus.imem_rsp_valid;

    // in-flight requests plus buffered words never exceed DEPTH, so every response has a slot
    assign bus.imem_req_valid = state_q == ST_RUN && !bus.redirect_valid && !full &&
                                ({1'b0, outst_q} + {1'b0, count}) < (CW+1)'(DEPTH);
    assign bus.imem_addr      = fetch_pc_q;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    // stale responses arrive only in FLUSH or alongside a redirect; everything else is live
    assign push    = rsp && state_q == ST_RUN && !bus.redirect_valid;
    assign pop     = bus.out_valid && bus.out_ready;
    assign outst_d = outst_q + CW'(accept) - CW'(rsp);

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
        end else if (redir) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            drop_d     = (state_q == ST_FLUSH ? drop_q : outst_q) - CW'(rsp);
            state_d    = (state_q == ST_FLUSH || drop_d != '0) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH) begin
            drop_d  = drop_q - CW'(rsp);
            state_d = drop_d == '0 ? ST_RUN : ST_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .wdata ({bus.imem_rsp_data, rsp_pc_q}),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head           = fetch_entry_t'(rdata);
    assign bus.out_valid  = !empty && !bus.redirect_valid;
    // buffer slots are not reset, so outputs are zeroed whenever nothing valid is presented
    assign bus.out_instr  = bus.out_valid ? head.instr : '0;
    assign bus.out_pc     = bus.out_valid ? head.pc : '0;
    assign bus.out_opcode = bus.out_instr[6:0];
    assign bus.out_funct3 = bus.out_instr[14:12];
    assign bus.out_funct7 = bus.out_instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based fetch model and per-cycle comparison
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct { logic [31:0] addr; bit stale; } inf_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    logic        clk, rst_n;
    logic        rdy, ordy, rdv, rsp_r;
    logic [31:0] rpc, rsp_d;
    int          mem_lat, cyc, checks, errors, first_rsp, first_ov;

    inf_t        m_inf[$];
    ent_t        m_buf[$];
    mreq_t       mem_q[$];
    logic [31:0] acc_log[$], pop_log[$];
    logic [31:0] m_pc;
    bit          m_idle, m_flush;

    fetch_unit_if bus();

    assign bus.imem_req_ready = rdy;
    assign bus.out_ready      = ordy;
    assign bus.redirect_valid = rdv;
    assign bus.redirect_pc    = rpc;
    assign bus.imem_rsp_valid = rsp_r & rst_n;
    assign bus.imem_rsp_data  = rsp_d;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h300 ? 32'h0020_81B3 : (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return q.size() > i ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // memory: answers accepted requests in order, no earlier than mem_lat cycles later
    initial begin
        rsp_r = 0;
        rsp_d = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                rsp_r = 1;
                rsp_d = mem_word(mem_q[0].addr);
            end else begin
                rsp_r = 0;
            end
        end
    end

    // reference model and per-cycle comparison
    initial begin
        inf_t        e;
        ent_t        h;
        bit          ev_ov, ev_rq;
        logic [31:0] w;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
                chk("rst_out_valid", 32'(bus.out_valid), 0);
                chk("rst_out_instr", bus.out_instr, 0);
                chk("rst_out_pc", bus.out_pc, 0);
                m_inf.delete();
                m_buf.delete();
                mem_q.delete();
                m_idle  = 1;
                m_flush = 0;
                m_pc    = RESET_PC;
                cyc     = 0;
            end else begin
                ev_ov = m_buf.size() > 0 && !rdv;
                ev_rq = !m_idle && !m_flush && !rdv && (m_inf.size() + m_buf.size() < DEPTH);
                chk("out_valid", 32'(bus.out_valid), 32'(ev_ov));
                chk("req_valid", 32'(bus.imem_req_valid), 32'(ev_rq));
                if (ev_rq) chk("imem_addr", bus.imem_addr, m_pc);
                if (ev_ov) begin
                    h = m_buf[0];
                    w = h.instr;
                    chk("out_pc", bus.out_pc, h.pc);
                    chk("out_instr", bus.out_instr, w);
                    chk("out_opcode", 32'(bus.out_opcode), 32'(w[6:0]));
                    chk("out_funct3", 32'(bus.out_funct3), 32'(w[14:12]));
                    chk("out_funct7", 32'(bus.out_funct7), 32'(w[31:25]));
                end
                if (bus.out_valid && first_ov < 0) first_ov = cyc;
                if (ev_ov && ordy) begin
                    pop_log.push_back(m_buf[0].pc);
                    void'(m_buf.pop_front());
                end
                if (bus.imem_rsp_valid) begin
                    if (first_rsp < 0) first_rsp = cyc;
                    if (mem_q.size() > 0) void'(mem_q.pop_front());
                    if (m_inf.size() > 0) begin
                        e = m_inf.pop_front();
                        if (!e.stale && !rdv) m_buf.push_back('{pc: e.addr, instr: mem_word(e.addr)});
                    end
                end
                if (bus.imem_req_valid && rdy) mem_q.push_back('{addr: bus.imem_addr, due: cyc + mem_lat});
                if (ev_rq && rdy) begin
                    m_inf.push_back('{addr: m_pc, stale: 0});
                    acc_log.push_back(m_pc);
                    m_pc += 4;
                end
                if (rdv && !m_idle) begin
                    m_buf.delete();
                    foreach (m_inf[i]) m_inf[i].stale = 1;
                    m_pc    = rpc & ~32'h3;
                    m_flush = m_flush || m_inf.size() > 0;
                end else if (m_flush) begin
                    m_flush = m_inf.size() > 0;
                end
                m_idle = 0;
                cyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        acc_log.delete();
        pop_log.delete();
        first_rsp = -1;
        first_ov  = -1;
        rst_n = 1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        rdv = 1;
        rpc = pc;
        pop_log.delete();
        tick();
        rdv = 0;
    endtask

    task automatic wait_req(output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid) seen = 1;
            else n++;
        end
        chk("req_seen", 32'(seen), 1);
    endtask

    task automatic wait_pop();
        bit seen;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid && ordy) seen = 1;
        end
        chk("pop_seen", 32'(seen), 1);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; first_rsp = -1; first_ov = -1;
        rst_n = 0; rdy = 1; ordy = 1; rdv = 0; rpc = 0; mem_lat = 1;

        do_reset();
        repeat (12) tick();
        chk("t1_addr0", q_at(acc_log, 0), 32'h0);
        chk("t1_addr1", q_at(acc_log, 1), 32'h4);
        chk("t1_addr2", q_at(acc_log, 2), 32'h8);
        chk("t1_first_pc", q_at(pop_log, 0), 32'h0);
        chk("t1_latency", 32'(first_ov - first_rsp), 1);

        ordy = 0;
        do_reset();
        repeat (10) tick();
        chk("t2_accepts", 32'(acc_log.size()), DEPTH);
        @(negedge clk);
        chk("t2_req_valid", 32'(bus.imem_req_valid), 0);
        chk("t2_out_valid", 32'(bus.out_valid), 1);
        tick();
        ordy = 1;
        repeat (10) tick();
        chk("t2_pop0", q_at(pop_log, 0), 32'h0);
        chk("t2_pop1", q_at(pop_log, 1), 32'h4);
        chk("t2_pop2", q_at(pop_log, 2), 32'h8);
        chk("t2_pop3", q_at(pop_log, 3), 32'hC);

        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick();
        chk("t3_two_outstanding", 32'(acc_log.size()), 2);
        redirect_to(32'h100);
        wait_req(n);
        chk("t3_flush_cycles", 32'(n), 2);
        chk("t3_next_addr", bus.imem_addr, 32'h100);
        wait_pop();
        tick();
        chk("t3_first_pc", q_at(pop_log, 0), 32'h100);

        mem_lat = 1;
        redirect_to(32'h203);
        wait_req(n);
        chk("t4_aligned_addr", bus.imem_addr, 32'h200);

        tick();
        redirect_to(32'h300);
        wait_pop();
        chk("t5_instr", bus.out_instr, 32'h0020_81B3);
        chk("t5_opcode", 32'(bus.out_opcode), 51);
        chk("t5_funct3", 32'(bus.out_funct3), 0);
        chk("t5_funct7", 32'(bus.out_funct7), 0);
        chk("t5_pc", bus.out_pc, 32'h300);

        tick();
        mem_lat = 4;
        tick();
        redirect_to(32'h400);
        wait_req(n);
        tick();
        tick();
        redirect_to(32'h500);
        chk("t6_in_flush", 32'(bus.imem_req_valid), 0);
        rst_n = 0;
        #1;
        chk("t6_req_valid", 32'(bus.imem_req_valid), 0);
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_out_instr", bus.out_instr, 0);
        chk("t6_out_pc", bus.out_pc, 0);
        chk("t6_addr", bus.imem_addr, RESET_PC);
        do_reset();
        for (int i = 0; i < 20 && acc_log.size() == 0; i++) tick();
        chk("t6_restart_addr", q_at(acc_log, 0), RESET_PC);
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
